// File: rtl/lsu_mem_port.sv
// Load/store unit: one outstanding access on a req/gnt/rvalid data memory port,
// active-low lane enables, sign/zero-extended loads. Define LSU_MISALIGNED_SPLIT_EN
// to split word-crossing accesses into two beats instead of failing them.
module lsu_mem_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_ben,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
);
    localparam int NB = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int SH_W = $clog2(DATA_W) + 1;
    localparam logic [4:0] NB5 = 5'(NB);

`ifdef LSU_MISALIGNED_SPLIT_EN
    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;
`else
    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, RESP} state_t;
`endif

    state_t state_reg, state_next;
    logic              we_reg, we_next;
    logic [1:0]        size_reg, size_next;
    logic              uns_reg, uns_next;
    logic [OFF_W-1:0]  off_reg, off_next;
    logic              mem_req_reg, mem_req_next;
    logic              mem_we_reg, mem_we_next;
    logic [NB-1:0]     mem_ben_reg, mem_ben_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic              rsp_err_reg, rsp_err_next;
    logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;

    logic [OFF_W-1:0]  req_off;
    logic [4:0]        req_bytes, req_end;
    logic [SH_W-1:0]   req_sh, lat_sh0, lat_sh1;
    logic [NB-1:0]     ben0;
    logic              req_illegal;

    assign req_off   = req_addr[OFF_W-1:0];
    assign req_bytes = 5'd1 << req_size;
    assign req_end   = 5'(req_off) + req_bytes;
    assign req_sh    = SH_W'({req_off, 3'b000});
    assign lat_sh0   = SH_W'({off_reg, 3'b000});
    assign lat_sh1   = SH_W'(DATA_W) - lat_sh0;

`ifdef LSU_MISALIGNED_SPLIT_EN
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [DATA_W-1:0] beat0_reg, beat0_next;
    logic [4:0]        lat_bytes, lat_end;
    logic [NB-1:0]     ben1;
    assign lat_bytes   = 5'd1 << size_reg;
    assign lat_end     = 5'(off_reg) + lat_bytes;
    assign req_illegal = req_bytes > NB5;
`else
    assign req_illegal = (req_bytes > NB5) || (req_end > NB5);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            localparam logic [4:0] LANE = 5'(gi);
            assign ben0[gi] = !((LANE >= 5'(req_off)) && (LANE < req_end));
`ifdef LSU_MISALIGNED_SPLIT_EN
            assign ben1[gi] = !(LANE < (lat_end - NB5));
`endif
        end
    endgenerate

    // Bits above the access size are always rebuilt, so stale upper lanes never leak out.
    function automatic logic [DATA_W-1:0] load_result(
        input logic [DATA_W-1:0] b0,
        input logic [DATA_W-1:0] b1,
        input logic [SH_W-1:0]   s0,
        input logic [SH_W-1:0]   s1,
        input logic [1:0]        size,
        input logic              uns
    );
        logic [DATA_W-1:0] raw, ext, sign_bit;
        int nbits;
        nbits    = 8 << size;
        raw      = (b0 >> s0) | (b1 << s1);
        ext      = ~((DATA_W'(1) << nbits) - DATA_W'(1));
        sign_bit = DATA_W'(1) << (nbits - 1);
        if (uns || ((raw & sign_bit) == '0))
            return raw & ~ext;
        return raw | ext;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            we_reg        <= 1'b0;
            size_reg      <= '0;
            uns_reg       <= 1'b0;
            off_reg       <= '0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_ben_reg   <= '1;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            wdata_reg     <= '0;
            beat0_reg     <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            we_reg        <= we_next;
            size_reg      <= size_next;
            uns_reg       <= uns_next;
            off_reg       <= off_next;
            mem_req_reg   <= mem_req_next;
            mem_we_reg    <= mem_we_next;
            mem_ben_reg   <= mem_ben_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_err_reg   <= rsp_err_next;
            rsp_rdata_reg <= rsp_rdata_next;
`ifdef LSU_MISALIGNED_SPLIT_EN
            wdata_reg     <= wdata_next;
            beat0_reg     <= beat0_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        we_next        = we_reg;
        size_next      = size_reg;
        uns_next       = uns_reg;
        off_next       = off_reg;
        mem_req_next   = mem_req_reg;
        mem_we_next    = mem_we_reg;
        mem_ben_next   = mem_ben_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_err_next   = rsp_err_reg;
        rsp_rdata_next = rsp_rdata_reg;
`ifdef LSU_MISALIGNED_SPLIT_EN
        wdata_next     = wdata_reg;
        beat0_next     = beat0_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    we_next   = req_write;
                    size_next = req_size;
                    uns_next  = req_unsigned;
                    off_next  = req_off;
`ifdef LSU_MISALIGNED_SPLIT_EN
                    wdata_next = req_wdata;
                    beat0_next = '0;
`endif
                    if (req_illegal) begin
                        state_next     = RESP;
                        rsp_valid_next = 1'b1;
                        rsp_err_next   = 1'b1;
                        rsp_rdata_next = '0;
                    end else begin
                        state_next     = REQ0;
                        mem_req_next   = 1'b1;
                        mem_we_next    = req_write;
                        mem_addr_next  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        mem_ben_next   = ben0;
                        mem_wdata_next = req_wdata << req_sh;
                    end
                end
            end
            REQ0: begin
                if (mem_gnt) begin
                    mem_req_next = 1'b0;
                    state_next   = WAIT0;
                end
            end
            WAIT0: begin
                if (mem_rvalid) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                    if (lat_end > NB5) begin
                        beat0_next     = mem_rdata;
                        state_next     = REQ1;
                        mem_req_next   = 1'b1;
                        mem_addr_next  = mem_addr_reg + ADDR_W'(NB);
                        mem_ben_next   = ben1;
                        mem_wdata_next = wdata_reg >> lat_sh1;
                    end else
`endif
                    begin
                        state_next     = RESP;
                        rsp_valid_next = 1'b1;
                        rsp_err_next   = 1'b0;
                        rsp_rdata_next = we_reg ? '0 :
                            load_result(mem_rdata, '0, lat_sh0, lat_sh1, size_reg, uns_reg);
                    end
                end
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            REQ1: begin
                if (mem_gnt) begin
                    mem_req_next = 1'b0;
                    state_next   = WAIT1;
                end
            end
            WAIT1: begin
                if (mem_rvalid) begin
                    state_next     = RESP;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b0;
                    rsp_rdata_next = we_reg ? '0 :
                        load_result(beat0_reg, mem_rdata, lat_sh0, lat_sh1, size_reg, uns_reg);
                end
            end
`endif
            RESP: begin
                state_next     = IDLE;
                rsp_valid_next = 1'b0;
                rsp_err_next   = 1'b0;
            end
            default: state_next = IDLE;
        endcase
    end

    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_ben   = mem_ben_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: a 32-bit instance with a scripted memory responder
// and a 64-bit instance for double-word accesses.
module tb_lsu_mem_port;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 0, req_write = 0, req_unsigned = 0;
    logic [1:0]  req_size = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        req_ready, rsp_valid, rsp_err, mem_req, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_ben;
    logic        mem_gnt = 0, mem_rvalid = 0;
    logic [31:0] mem_rdata = 0;

    logic        r64_valid = 0, r64_write = 0, r64_unsigned = 0;
    logic [1:0]  r64_size = 0;
    logic [31:0] r64_addr = 0;
    logic [63:0] r64_wdata = 0;
    logic        r64_ready, rsp64_valid, rsp64_err, m64_req, m64_we;
    logic [63:0] rsp64_rdata, m64_wdata;
    logic [31:0] m64_addr;
    logic [7:0]  m64_ben;
    logic        m64_gnt = 0, m64_rvalid = 0;
    logic [63:0] m64_rdata = 0;

    lsu_mem_port #(.DATA_W(32), .ADDR_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
        .mem_ben(mem_ben), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    lsu_mem_port #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
        .clk(clk), .rst(rst),
        .req_valid(r64_valid), .req_ready(r64_ready), .req_write(r64_write),
        .req_size(r64_size), .req_unsigned(r64_unsigned), .req_addr(r64_addr),
        .req_wdata(r64_wdata), .rsp_valid(rsp64_valid), .rsp_rdata(rsp64_rdata),
        .rsp_err(rsp64_err), .mem_req(m64_req), .mem_gnt(m64_gnt), .mem_we(m64_we),
        .mem_ben(m64_ben), .mem_addr(m64_addr), .mem_wdata(m64_wdata),
        .mem_rvalid(m64_rvalid), .mem_rdata(m64_rdata)
    );

    int tests = 0;
    int fails = 0;

    // Per-access observations gathered by the responder.
    int          nbeats, lat;
    logic [31:0] b_addr[2], b_wdata[2];
    logic [3:0]  b_ben[2];
    logic        b_we, stable, r_err;
    logic [31:0] r_data;
    logic [7:0]  b64_ben;
    logic [31:0] b64_addr;
    logic        b64_req, b64_valid;
    logic [63:0] b64_data;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request on the 32-bit unit; memory grants after gnt_dly request cycles
    // and returns rvalid the following cycle. lat = cycles from accept to rsp_valid.
    task automatic access(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd0, input logic [31:0] rd1, input int gnt_dly);
        int  reqc;
        logic pend;
        req_valid = 1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        tick;
        req_valid = 0;
        nbeats = 0; stable = 1; lat = -1; r_data = 0; r_err = 0; b_we = 0;
        reqc = 0; pend = 0;
        for (int k = 1; k <= 40; k++) begin
            mem_rvalid = pend;
            mem_rdata  = (nbeats == 2) ? rd1 : rd0;
            pend = 0;
            mem_gnt = 0;
            if (rsp_valid) begin
                lat = k; r_data = rsp_rdata; r_err = rsp_err;
                break;
            end
            if (mem_req && nbeats < 2) begin
                if (reqc == 0) begin
                    b_addr[nbeats] = mem_addr; b_ben[nbeats] = mem_ben;
                    b_wdata[nbeats] = mem_wdata; b_we = mem_we;
                end else if (mem_addr !== b_addr[nbeats] || mem_ben !== b_ben[nbeats] ||
                             mem_wdata !== b_wdata[nbeats]) begin
                    stable = 0;
                end
                if (reqc == gnt_dly) begin
                    mem_gnt = 1; pend = 1; nbeats++; reqc = 0;
                end else begin
                    reqc++;
                end
            end
            tick;
        end
        mem_rvalid = 0;
        mem_gnt = 0;
        tick;
        chk("ready_after_rsp", 64'(req_ready), 64'd1);
        chk("rsp_one_cycle", 64'(rsp_valid), 64'd0);
    endtask

    task automatic acc64(input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                         input logic [63:0] rd);
        r64_valid = 1; r64_size = sz; r64_unsigned = uns; r64_addr = addr;
        tick;
        r64_valid = 0;
        m64_gnt = 1;
        b64_ben = m64_ben; b64_addr = m64_addr; b64_req = m64_req;
        tick;
        m64_gnt = 0; m64_rvalid = 1; m64_rdata = rd;
        tick;
        m64_rvalid = 0;
        b64_valid = rsp64_valid; b64_data = rsp64_rdata;
        tick;
    endtask

    initial begin
        tick;
        tick;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_ben", 64'(mem_ben), 64'hF);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_mem_ben64", 64'(m64_ben), 64'hFF);
        rst = 0;
        tick;

        access(0, 2'd0, 0, 32'h103, 32'h0, 32'h80AA_BBCC, 32'h0, 0);
        chk("lb_addr", 64'(b_addr[0]), 64'h100);
        chk("lb_ben", 64'(b_ben[0]), 64'h7);
        chk("lb_we", 64'(b_we), 64'd0);
        chk("lb_lat", 64'(lat), 64'd3);
        chk("lb_rdata", 64'(r_data), 64'hFFFF_FF80);
        chk("lb_err", 64'(r_err), 64'd0);

        access(0, 2'd0, 1, 32'h103, 32'h0, 32'h80AA_BBCC, 32'h0, 0);
        chk("lbu_rdata", 64'(r_data), 64'h0000_0080);

        access(1, 2'd1, 0, 32'h202, 32'h0000_1234, 32'h0, 32'h0, 0);
        chk("sh_addr", 64'(b_addr[0]), 64'h200);
        chk("sh_ben", 64'(b_ben[0]), 64'h3);
        chk("sh_wdata", 64'(b_wdata[0]), 64'h1234_0000);
        chk("sh_we", 64'(b_we), 64'd1);
        chk("sh_lat", 64'(lat), 64'd3);
        chk("sh_rdata", 64'(r_data), 64'd0);

        access(0, 2'd1, 0, 32'h002, 32'h0, 32'h8001_ABCD, 32'h0, 3);
        chk("lh_dly_stable", 64'(stable), 64'd1);
        chk("lh_dly_ben", 64'(b_ben[0]), 64'h3);
        chk("lh_dly_lat", 64'(lat), 64'd6);
        chk("lh_dly_rdata", 64'(r_data), 64'hFFFF_8001);

        access(0, 2'd3, 0, 32'h010, 32'h0, 32'h0, 32'h0, 0);
        chk("size3_err", 64'(r_err), 64'd1);
        chk("size3_lat", 64'(lat), 64'd1);
        chk("size3_beats", 64'(nbeats), 64'd0);

        access(0, 2'd2, 0, 32'h0FFE, 32'h0, 32'hBBAA_1111, 32'h2222_DDCC, 0);
`ifdef LSU_MISALIGNED_SPLIT_EN
        chk("split_beats", 64'(nbeats), 64'd2);
        chk("split_addr0", 64'(b_addr[0]), 64'hFFC);
        chk("split_ben0", 64'(b_ben[0]), 64'h3);
        chk("split_addr1", 64'(b_addr[1]), 64'h1000);
        chk("split_ben1", 64'(b_ben[1]), 64'hC);
        chk("split_lat", 64'(lat), 64'd5);
        chk("split_rdata", 64'(r_data), 64'hDDCC_BBAA);
        chk("split_err", 64'(r_err), 64'd0);
`else
        chk("cross_err", 64'(r_err), 64'd1);
        chk("cross_lat", 64'(lat), 64'd1);
        chk("cross_beats", 64'(nbeats), 64'd0);
`endif

        // Reset while waiting for read data, then a stray rvalid.
        req_valid = 1; req_write = 0; req_size = 2'd2; req_unsigned = 0; req_addr = 32'h40;
        tick;
        req_valid = 0;
        mem_gnt = 1;
        chk("rstmid_req", 64'(mem_req), 64'd1);
        tick;
        mem_gnt = 0;
        rst = 1;
        tick;
        rst = 0;
        chk("rstmid_ready", 64'(req_ready), 64'd1);
        chk("rstmid_mem_req", 64'(mem_req), 64'd0);
        mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
        tick;
        mem_rvalid = 0;
        chk("rstmid_no_rsp0", 64'(rsp_valid), 64'd0);
        tick;
        chk("rstmid_no_rsp1", 64'(rsp_valid), 64'd0);
        access(0, 2'd2, 0, 32'h40, 32'h0, 32'h1122_3344, 32'h0, 0);
        chk("after_rst_lat", 64'(lat), 64'd3);
        chk("after_rst_rdata", 64'(r_data), 64'h1122_3344);

        acc64(2'd3, 0, 32'h8, 64'h8123_4567_89AB_CDEF);
        chk("ld64_req", 64'(b64_req), 64'd1);
        chk("ld64_ben", 64'(b64_ben), 64'h00);
        chk("ld64_addr", 64'(b64_addr), 64'h8);
        chk("ld64_valid", 64'(b64_valid), 64'd1);
        chk("ld64_rdata", b64_data, 64'h8123_4567_89AB_CDEF);
        chk("ld64_err", 64'(rsp64_err), 64'd0);

        acc64(2'd0, 0, 32'hF, 64'h80FF_FFFF_FFFF_FFFF);
        chk("lb64_ben", 64'(b64_ben), 64'h7F);
        chk("lb64_addr", 64'(b64_addr), 64'h8);
        chk("lb64_rdata", b64_data, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb64_ready", 64'(r64_ready), 64'd1);
        chk("lb64_we", 64'(m64_we), 64'd0);
        chk("lb64_wdata", m64_wdata, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
